// File: rtl/line_buffer_3x3_pkg.sv
// Shared widths, FSM encodings and the output column record for the 3x3 line buffer.
// Also holds the default frame size and a wrapping counter helper.
package line_buffer_3x3_pkg;

    localparam int PIX_W    = 8;
    localparam int IDX_W    = 10;
    localparam int DEF_ROWS = 480;
    localparam int DEF_COLS = 640;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    typedef struct packed {
        logic [PIX_W-1:0] d5;
        logic [PIX_W-1:0] d4;
        logic [PIX_W-1:0] d3;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } column_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v,
                                                  input logic [IDX_W-1:0] last);
        return (v == last) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One-row line memory: synchronous write, combinational read.
// A read and a write to the same address in one cycle return the old contents.
module line_buffer_ram
    import line_buffer_3x3_pkg::*;
#(
    parameter int DEPTH = DEF_COLS,
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Deliberately not reset: stale rows are masked by the FSM, not cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_buffer_3x3.sv
// Turns a raster pixel stream into vertical 3-pixel columns (rows r-1, r, r+1) for every centre pixel.
// Two line memories hold the previous two rows; the last row is flushed after the final input pixel.
module line_buffer_3x3
    import line_buffer_3x3_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic [PIX_W-1:0] d5_o,
    output logic [PIX_W-1:0] d4_o,
    output logic [PIX_W-1:0] d3_o,
    output logic             col_valid_o,
    input  logic             col_ready_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             frame_done_o
);

    localparam logic [IDX_W-1:0] LAST_R = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(COLS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] in_r_q, in_r_d;
    logic [IDX_W-1:0] in_c_q, in_c_d;
    logic [IDX_W-1:0] out_c_q, out_c_d;
    column_t          out_q, out_d;
    logic             valid_q, valid_d;
    logic             run_q;

    logic             out_free, pix_acc, col_acc, last_out;
    logic [IDX_W-1:0] raddr;
    logic [PIX_W-1:0] top_rd, mid_rd;

    assign out_free = !valid_q || col_ready_i;
    // run_q keeps the input closed while reset is asserted and for the first cycle after it.
    assign pix_ready_o = run_q && (state_q != ST_FLUSH) && out_free;
    assign pix_acc  = pix_valid_i && pix_ready_o;
    assign col_acc  = valid_q && col_ready_i;
    assign last_out = valid_q && (out_q.row == LAST_R) && (out_q.col == LAST_C);
    assign raddr    = (state_q == ST_FLUSH) ? out_c_q : in_c_q;

    line_buffer_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb_top (
        .clk     (clk),
        .we_i    (pix_acc),
        .waddr_i (in_c_q),
        .wdata_i (mid_rd),
        .raddr_i (raddr),
        .rdata_o (top_rd)
    );

    line_buffer_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb_mid (
        .clk     (clk),
        .we_i    (pix_acc),
        .waddr_i (in_c_q),
        .wdata_i (pix_i),
        .raddr_i (raddr),
        .rdata_o (mid_rd)
    );

    always_comb begin
        state_d = state_q;
        in_r_d  = in_r_q;
        in_c_d  = in_c_q;
        out_c_d = out_c_q;
        out_d   = out_q;
        valid_d = valid_q && !col_ready_i;
        case (state_q)
            ST_FILL: begin
                if (pix_acc) begin
                    in_c_d = wrap_inc(in_c_q, LAST_C);
                    if (in_c_q == LAST_C) begin
                        in_r_d  = IDX_W'(1);
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (pix_acc) begin
                    out_d.d5  = (in_r_q == IDX_W'(1)) ? '0 : top_rd;
                    out_d.d4  = mid_rd;
                    out_d.d3  = pix_i;
                    out_d.row = in_r_q - 1'b1;
                    out_d.col = in_c_q;
                    valid_d   = 1'b1;
                    in_c_d    = wrap_inc(in_c_q, LAST_C);
                    if (in_c_q == LAST_C) begin
                        if (in_r_q == LAST_R) begin
                            in_r_d  = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            in_r_d = in_r_q + 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // The frame ends only when the final column leaves, not when it is loaded.
                if (col_acc && last_out) begin
                    state_d = ST_FILL;
                end else if (out_free && !last_out) begin
                    out_d.d5  = top_rd;
                    out_d.d4  = mid_rd;
                    out_d.d3  = '0;
                    out_d.row = LAST_R;
                    out_d.col = out_c_q;
                    valid_d   = 1'b1;
                    out_c_d   = wrap_inc(out_c_q, LAST_C);
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            in_r_q  <= '0;
            in_c_q  <= '0;
            out_c_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_r_q  <= in_r_d;
            in_c_q  <= in_c_d;
            out_c_q <= out_c_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            run_q   <= 1'b1;
        end
    end

    assign d5_o         = out_q.d5;
    assign d4_o         = out_q.d4;
    assign d3_o         = out_q.d3;
    assign row_o        = out_q.row;
    assign col_o        = out_q.col;
    assign col_valid_o  = valid_q;
    assign frame_done_o = col_acc && last_out;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Bench for line_buffer_3x3: a 4x4 and a 2x3 instance, a frame-level column model and a per-cycle checker.
// Expected columns come from whole-frame arithmetic on the pixel array (neighbour rows, zero outside).
module tb_line_buffer_3x3;

  localparam int W = 44;

  logic clk;
  logic rst_n;

  logic [7:0] a_pix, a_d5, a_d4, a_d3;
  logic a_pv, a_pr, a_cv, a_cr, a_fd;
  logic [9:0] a_row, a_col;
  logic [7:0] b_pix, b_d5, b_d4, b_d3;
  logic b_pv, b_pr, b_cv, b_cr, b_fd;
  logic [9:0] b_row, b_col;

  line_buffer_3x3 #(.ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_i(a_pix), .pix_valid_i(a_pv), .pix_ready_o(a_pr),
    .d5_o(a_d5), .d4_o(a_d4), .d3_o(a_d3), .col_valid_o(a_cv), .col_ready_i(a_cr),
    .row_o(a_row), .col_o(a_col), .frame_done_o(a_fd)
  );

  line_buffer_3x3 #(.ROWS(2), .COLS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_i(b_pix), .pix_valid_i(b_pv), .pix_ready_o(b_pr),
    .d5_o(b_d5), .d4_o(b_d4), .d3_o(b_d3), .col_valid_o(b_cv), .col_ready_i(b_cr),
    .row_o(b_row), .col_o(b_col), .frame_done_o(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] in_q[$];
  logic [W-1:0] exp_q[$];
  int sel = 0;
  int cur_rows = 4;
  int cur_cols = 4;
  int frames_done = 0;
  int pix_acc_cnt = 0;
  bit held_valid = 1'b0;
  logic [W-1:0] held = '0;
  bit tog = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: column (r,c) = pixel above, pixel itself, pixel below; rows outside the frame read 0.
  task automatic add_frame(input int kind);
    logic [7:0] px[];
    logic [7:0] d5, d4, d3;
    px = new[cur_rows * cur_cols];
    for (int r = 0; r < cur_rows; r++)
      for (int c = 0; c < cur_cols; c++) begin
        case (kind)
          0: px[r*cur_cols+c] = 8'(16 * r + c);
          1: px[r*cur_cols+c] = 8'hFF;
          default: px[r*cur_cols+c] = 8'($urandom_range(0, 255));
        endcase
        in_q.push_back(px[r*cur_cols+c]);
      end
    for (int r = 0; r < cur_rows; r++)
      for (int c = 0; c < cur_cols; c++) begin
        d5 = (r == 0) ? 8'h00 : px[(r-1)*cur_cols+c];
        d4 = px[r*cur_cols+c];
        d3 = (r == cur_rows - 1) ? 8'h00 : px[(r+1)*cur_cols+c];
        exp_q.push_back({10'(r), 10'(c), d5, d4, d3});
      end
  endtask

  // rdy_pct: 0..100 probability of col_ready, 101 = alternate every cycle.
  task automatic step(input int rdy_pct, input int vld_pct);
    bit pv, cr;
    logic [W-1:0] obs, e;
    logic s_pr, s_cv, s_fd;
    @(negedge clk);
    pv = (in_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
    if (rdy_pct > 100) begin
      cr = tog;
      tog = ~tog;
    end else begin
      cr = ($urandom_range(0, 99) < rdy_pct);
    end
    if (sel == 0) begin
      a_pv = pv; a_pix = pv ? in_q[0] : 8'h00; a_cr = cr;
    end else begin
      b_pv = pv; b_pix = pv ? in_q[0] : 8'h00; b_cr = cr;
    end
    #1;
    if (sel == 0) begin
      obs = {a_row, a_col, a_d5, a_d4, a_d3}; s_pr = a_pr; s_cv = a_cv; s_fd = a_fd;
    end else begin
      obs = {b_row, b_col, b_d5, b_d4, b_d3}; s_pr = b_pr; s_cv = b_cv; s_fd = b_fd;
    end
    if (held_valid) check("hold_while_stalled", {s_cv, obs}, {1'b1, held});
    if (s_cv && !cr) check("pix_ready_while_stalled", s_pr, 1'b0);
    if (pv && s_pr) begin
      check("pixel_before_frame_end", 64'(frames_done >= pix_acc_cnt / (cur_rows * cur_cols)), 64'd1);
      pix_acc_cnt++;
      void'(in_q.pop_front());
    end
    if (s_cv && cr) begin
      if (exp_q.size() == 0) begin
        check("extra_column", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("column", obs, e);
        check("frame_done", s_fd,
              64'((int'(e[43:34]) == cur_rows - 1) && (int'(e[33:24]) == cur_cols - 1)));
      end
      if (s_fd) frames_done++;
    end else begin
      check("frame_done_idle", s_fd, 1'b0);
    end
    held_valid = s_cv && !cr;
    held = obs;
  endtask

  task automatic idle();
    @(negedge clk);
    a_pv = 1'b0; b_pv = 1'b0; a_cr = 1'b1; b_cr = 1'b1;
  endtask

  task automatic run(input int rdy_pct, input int vld_pct, input int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(rdy_pct, vld_pct);
      n++;
    end
    check("drained_within_budget", 64'(in_q.size() + exp_q.size()), 0);
    idle();
  endtask

  task automatic clear_model();
    in_q.delete();
    exp_q.delete();
    frames_done = 0;
    pix_acc_cnt = 0;
    held_valid = 1'b0;
  endtask

  task automatic reset_and_check();
    #1;
    check("reset_outputs_a", {a_d5, a_d4, a_d3, a_row, a_col, a_cv, a_pr, a_fd}, 0);
    check("reset_outputs_b", {b_d5, b_d4, b_d3, b_row, b_col, b_cv, b_pr, b_fd}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    rst_n = 1'b0;
    a_pv = 1'b0; a_pix = 8'h00; a_cr = 1'b1;
    b_pv = 1'b0; b_pix = 8'h00; b_cr = 1'b1;
    reset_and_check();

    // 4x4 counting pattern, downstream always ready.
    sel = 0; cur_rows = 4; cur_cols = 4;
    add_frame(0);
    run(100, 100, 400);
    check("one_frame_done_pulse", 64'(frames_done), 1);

    // Same frame with col_ready alternating.
    add_frame(0);
    run(101, 100, 400);
    check("frames_after_toggle_run", 64'(frames_done), 2);

    // Back-to-back frames, second all 0xFF: its row-0 tops must be 0.
    add_frame(0);
    add_frame(1);
    run(100, 100, 400);
    check("frames_after_back_to_back", 64'(frames_done), 4);

    // Random pixels, random valid and ready.
    add_frame(2);
    add_frame(2);
    add_frame(2);
    run(60, 70, 1500);
    check("frames_after_random", 64'(frames_done), 7);

    // Reset mid-STREAM after 9 pixels, then the pattern frame again.
    clear_model();
    add_frame(0);
    while (pix_acc_cnt < 9) step(100, 100);
    @(posedge clk);
    #2;
    a_pv = 1'b0;
    check("valid_before_reset", a_cv, 1'b1);
    rst_n = 1'b0;
    reset_and_check();
    add_frame(0);
    run(100, 100, 400);
    check("frames_after_reset", 64'(frames_done), 1);

    // 2x3 instance: pattern frame then random frames.
    sel = 1; cur_rows = 2; cur_cols = 3;
    clear_model();
    add_frame(0);
    add_frame(2);
    run(100, 100, 300);
    add_frame(2);
    add_frame(0);
    run(50, 80, 600);
    check("frames_small", 64'(frames_done), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
